// File: rtl/clock_enable_generator_if.sv
// clock_enable_generator_if: divider programming, realign request and the strobes/reset it returns
interface clock_enable_generator_if #(
   parameter int NUM_CHANNELS = 2,
   parameter int CNT_WIDTH    = 8
);
   logic [NUM_CHANNELS*CNT_WIDTH-1:0] div;
   logic                              sync_in;
   logic [NUM_CHANNELS-1:0]           clk_en;
   logic                              reset_out;
   logic                              ready;
   modport master (output div, sync_in, input clk_en, reset_out, ready);
   modport slave  (input div, sync_in, output clk_en, reset_out, ready);
endinterface

// File: rtl/clock_enable_generator.sv
// clock_enable_generator: pin clock pass-through, synchronised stretched reset and per-channel clock-enable strobes
module clock_enable_generator #(
   parameter int NUM_CHANNELS      = 2,
   parameter int CNT_WIDTH         = 8,
   parameter int RESET_SYNC_STAGES = 2,
   parameter int RESET_HOLD_CYCLES = 16
) (
   input  logic                     clk_from_pin,
   input  logic                     resetb_pin,
   output logic                     clk_out,
   clock_enable_generator_if.slave  bus
);
   localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
   typedef enum logic [1:0] {ST_RESET, ST_HOLD, ST_RUN} state_t;
   state_t                       state_q, state_d;
   logic [RESET_SYNC_STAGES-1:0] sync_q, sync_d;
   logic [HW-1:0]                hold_q, hold_d;
   logic                         run;
   assign clk_out       = clk_from_pin;
   assign run           = state_q == ST_RUN;
   assign bus.reset_out = !run;
   assign bus.ready     = run;
   // Reset FSM: HOLD begins on the edge where the synchroniser output goes high, so the state tracks that output exactly
   always_comb begin
      sync_d  = {sync_q[RESET_SYNC_STAGES-2:0], 1'b1};
      state_d = state_q;
      hold_d  = '0;
      case (state_q)
         ST_RESET: state_d = sync_q[RESET_SYNC_STAGES-2] ? ST_HOLD : ST_RESET;
         ST_HOLD: begin
            state_d = !sync_q[RESET_SYNC_STAGES-1] ? ST_RESET :
                      hold_q == HW'(RESET_HOLD_CYCLES - 1) ? ST_RUN : ST_HOLD;
            hold_d  = hold_q + 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
   end
   // Reset state, synchroniser chain and hold counter; the pin clears everything at once
   always_ff @(posedge clk_from_pin or negedge resetb_pin) begin
      if (!resetb_pin) begin
         state_q <= ST_RESET;
         sync_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         hold_q  <= hold_d;
      end
   end
   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d, shd_q, shd_d;
      logic                 last, reload;
      assign last = shd_q != '0 && cnt_q == shd_q - 1'b1;
      assign bus.clk_en[i] = run && last && !(bus.sync_in && shd_q > CNT_WIDTH'(1));
      // A wrap, a realign, a disabled channel or being out of RUN restarts the count and samples a fresh ratio
      always_comb begin
         reload = !run || bus.sync_in || shd_q == '0 || last;
         cnt_d  = reload ? '0 : cnt_q + 1'b1;
         shd_d  = reload ? bus.div[i*CNT_WIDTH +: CNT_WIDTH] : shd_q;
      end
      // Channel counter and shadow divider registers
      always_ff @(posedge clk_from_pin or negedge resetb_pin) begin
         if (!resetb_pin) begin
            cnt_q <= '0;
            shd_q <= '0;
         end else begin
            cnt_q <= cnt_d;
            shd_q <= shd_d;
         end
      end
   end
endmodule
